// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: framed SPI serial-clock generator with runtime divider, CPOL/CPHA strobes and abort
module spi_sclk_engine #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 6
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [BITS_W-1:0] i_nbits,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_sclk,
  output logic              o_sclk_rising_edge,
  output logic              o_sclk_falling_edge,
  output logic              o_sample_spi_data,
  output logic              o_setup_spi_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [BITS_W:0]   o_bit_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, div_q;
  logic [BITS_W-1:0] nbits_q;
  logic cpol_q, cpha_q, latch;
  logic [BITS_W+1:0] edge_q, edge_n, k, last_edge;
  logic ev, lead, sclk_n, rise_n, fall_n, sample_n, setup_n, done_n;
  logic [BITS_W:0] bit_cnt_n;
  assign ev = cnt == div_q;
  assign k = edge_q + (BITS_W+2)'(1);
  assign lead = k[0];
  // nbits of zero encodes a full 2^BITS_W-bit frame
  assign last_edge = nbits_q == '0 ? {1'b1, {(BITS_W+1){1'b0}}} : {1'b0, nbits_q, 1'b0};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    edge_n = edge_q;
    sclk_n = o_sclk;
    rise_n = 1'b0;
    fall_n = 1'b0;
    sample_n = 1'b0;
    setup_n = 1'b0;
    done_n = 1'b0;
    bit_cnt_n = o_bit_cnt;
    latch = 1'b0;
    case (state)
      IDLE: begin
        sclk_n = i_cpol;
        if (i_start && !i_abort) begin
          latch = 1'b1;
          state_n = RUN;
          cnt_n = '0;
          edge_n = '0;
          bit_cnt_n = '0;
          setup_n = !i_cpha;
        end
      end
      RUN: begin
        cnt_n = ev ? '0 : cnt + DIV_W'(1);
        if (ev) begin
          sclk_n = !o_sclk;
          rise_n = !o_sclk;
          fall_n = o_sclk;
          edge_n = k;
          sample_n = lead ^ cpha_q;
          setup_n = cpha_q ? lead : (!lead && k != last_edge);
          bit_cnt_n = o_bit_cnt + (BITS_W+1)'(sample_n);
          state_n = k == last_edge ? TAIL : RUN;
        end
      end
      TAIL: begin
        cnt_n = ev ? '0 : cnt + DIV_W'(1);
        state_n = ev ? IDLE : TAIL;
        done_n = ev;
      end
      default: state_n = IDLE;
    endcase
    // abort parks the clock at idle polarity silently, keeping the sample count
    if (i_abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n = cnt;
      edge_n = edge_q;
      sclk_n = cpol_q;
      rise_n = 1'b0;
      fall_n = 1'b0;
      sample_n = 1'b0;
      setup_n = 1'b0;
      done_n = 1'b0;
      bit_cnt_n = o_bit_cnt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt <= '0;
      edge_q <= '0;
      div_q <= '0;
      nbits_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      o_sclk <= 1'b0;
      o_sclk_rising_edge <= 1'b0;
      o_sclk_falling_edge <= 1'b0;
      o_sample_spi_data <= 1'b0;
      o_setup_spi_data <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_bit_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      edge_q <= edge_n;
      o_sclk <= sclk_n;
      o_sclk_rising_edge <= rise_n;
      o_sclk_falling_edge <= fall_n;
      o_sample_spi_data <= sample_n;
      o_setup_spi_data <= setup_n;
      o_busy <= state_n != IDLE;
      o_done <= done_n;
      o_bit_cnt <= bit_cnt_n;
      if (latch) begin
        div_q <= i_div;
        nbits_q <= i_nbits;
        cpol_q <= i_cpol;
        cpha_q <= i_cpha;
      end
    end
  end
endmodule

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

Programmable SPI master serial-clock engine: a parametrised successor to the fixed four-rate SPI clock generator. It provides a runtime half-period divider, frame-based operation (start/busy/done with a programmed bit count), mode-correct sample/setup strobes for all four CPOL/CPHA modes, and abort. It sits between the SPI control registers and the shift-register datapath of the AXI-to-SPI bridge. It drives SCLK only while a frame is active; otherwise SCLK is held at the idle polarity.

## Interface
- DIV_W, 8, width of the half-period divider value
- BITS_W, 6, width of the bit-count field; frame length is 1..2^BITS_W bits
- i_clk  in  1  system clock (10–200 MHz)
- i_reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of i_clk
- i_div  in  DIV_W  half-period minus one, in i_clk cycles
- i_nbits  in  BITS_W  bits per frame; 0 means 2^BITS_W
- i_cpol, i_cpha  in  1 each  SPI mode bits
- i_start  in  1  single-cycle frame request
- i_abort  in  1  terminate the frame immediately
- o_sclk  out  1  SPI clock, registered
- o_sclk_rising_edge, o_sclk_falling_edge  out  1 each  one-cycle strobes, high in the first cycle o_sclk shows the new level
- o_sample_spi_data, o_setup_spi_data  out  1 each  one-cycle datapath strobes
- o_busy  out  1  a frame is in progress
- o_done  out  1  one-cycle pulse when a frame ends normally
- o_bit_cnt  out  BITS_W+1  number of samples taken in the current or last frame

## Operation
- States:
  - IDLE: no frame in progress.
  - RUN: 2N SCLK edges, where N = i_nbits, or 2^BITS_W when i_nbits = 0.
  - TAIL: one extra half-period of hold time after the last edge.
- Reset (i_reset_n = 0): state IDLE; o_sclk, all strobes, o_busy, o_done, o_bit_cnt and the divider counter are 0.
- IDLE:
  - o_sclk is registered from the live i_cpol.
  - On i_start with i_abort = 0, latch i_div, i_nbits, i_cpol and i_cpha, clear o_bit_cnt and the counter, and enter RUN.
- Config inputs are ignored while o_busy = 1; the latched values are used for the whole frame.
- Divider:
  - The counter increments each cycle in RUN and TAIL.
  - When it reaches the latched div, it wraps to 0 and an edge event occurs. Half-period = div+1 cycles.
  - div = 0 gives SCLK = i_clk/2.
- Edge events:
  - In RUN, each event toggles o_sclk. Edges are numbered k = 1..2N; odd k are leading edges, even k are trailing edges.
  - The rising/falling strobe is chosen by the actual o_sclk transition, so it follows CPOL.
- CPHA = 0:
  - o_setup_spi_data fires in the first RUN cycle, for bit 0.
  - o_sample_spi_data fires on every leading edge.
  - o_setup_spi_data also fires on trailing edges k < 2N.
- CPHA = 1:
  - o_setup_spi_data fires on every leading edge.
  - o_sample_spi_data fires on every trailing edge.
  - There is no initial setup strobe.
- o_bit_cnt increments in the same cycle as each o_sample_spi_data.
- After edge 2N the block enters TAIL. The next divider event ends the frame: o_done = 1 for one cycle, o_busy = 0 in that same cycle, and the state returns to IDLE.
- In TAIL, o_sclk stays at the latched CPOL and no strobes fire.
- Boundaries:
  - i_start while busy: ignored.
  - i_start and i_abort together in IDLE: abort wins and no frame starts.
  - i_abort in RUN or TAIL: IDLE on the next cycle, with o_sclk = latched CPOL, no strobes, no o_done, and o_bit_cnt holding its value.
  - An abort that returns o_sclk to idle does not pulse the edge strobes.
  - Reset mid-frame: the reset values apply on the next edge, with no o_done.
  - Bit counts up to 2^BITS_W must not overflow; o_bit_cnt is BITS_W+1 bits wide.

## Timing
- i_start is sampled at clock edge T. From cycle T+1: o_busy = 1 and the counter is 0.
- For CPHA = 0, o_setup_spi_data is high in cycle T+1.
- Edge k: o_sclk shows its new level, and its strobes are high, in cycle T+1+k·(div+1).
- o_done is high in cycle T+1+(2N+1)·(div+1).
- The earliest accepted next i_start is in the o_done cycle. Its effect begins one cycle later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Mode 0, div = 0, nbits = 8, start at T:
  - o_sclk toggles in cycles T+2..T+17, with 8 rising-edge samples.
  - 8 setup strobes (T+1 plus 7 falling edges).
  - o_done at T+18 and o_bit_cnt = 8.
- Mode 3, div = 3, nbits = 1:
  - o_sclk idles at 1, then falls at T+5 (setup strobe) and rises at T+9 (sample strobe).
  - o_done at T+13.
- nbits = 0, div = 0, mode 1:
  - 128 edges, 64 samples on falling edges, o_bit_cnt = 64, o_done at T+130.
- Abort in RUN after 3 samples (mode 2):
  - The next cycle shows o_busy = 0, o_sclk = 1, no strobes, no o_done, o_bit_cnt = 3.
- i_start pulsed mid-frame, and i_div/i_cpol changed mid-frame:
  - The frame timing is unchanged and only one o_done occurs.
- i_reset_n low for one cycle mid-frame:
  - All outputs are 0 the next cycle, o_sclk then follows i_cpol, and a new start behaves normally.
